// File: rtl/sys_clkrst_gen.sv
// sys_clkrst_gen: reset synchroniser, reset stretcher and clock-enable
// generator for the CPU and VDC cores, clocked from the system PLL.
// Optional build macro SYS_CE_PAUSE_EN adds a 'pause' input that masks
// ce_cpu pulses while the system is running.
//
// Handshake note: this block has no valid/ready interfaces. ext_reset and
// pause are level requests sampled on every rising clk edge. ce_cpu and
// ce_vdc are single-cycle strobes that the consumer must act on in the
// cycle they are high.
module sys_clkrst_gen #(
  parameter int CPU_DIV     = 7,
  parameter int VDC_DIV     = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ext_reset,
`ifdef SYS_CE_PAUSE_EN
  input  logic pause,
`endif
  output logic sys_reset,
  output logic running,
  output logic ce_cpu,
  output logic ce_vdc
);

  localparam int CW = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam int VW = (VDC_DIV > 1) ? $clog2(VDC_DIV) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [CW-1:0] CPU_LAST  = CW'(CPU_DIV - 1);
  localparam logic [VW-1:0] VDC_LAST  = VW'(VDC_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_ALIGN = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync_n;
  logic [CW-1:0]          cpu_cnt;
  logic [VW-1:0]          vdc_cnt;
  logic                   cpu_tick;
  logic                   vdc_tick;
  state_t                 state;
  state_t                 state_d;
  logic [HW-1:0]          hold_cnt;
  logic [HW-1:0]          hold_cnt_d;

  // Reset synchroniser: asserts asynchronously, releases after SYNC_STAGES edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

  // Free-running dividers; phase is fixed by the release of rst_sync_n only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_cnt <= '0;
      vdc_cnt <= '0;
    end else if (!rst_sync_n) begin
      cpu_cnt <= '0;
      vdc_cnt <= '0;
    end else begin
      cpu_cnt <= cpu_tick ? '0 : cpu_cnt + 1'b1;
      vdc_cnt <= vdc_tick ? '0 : vdc_cnt + 1'b1;
    end
  end

  // A zero counter never equals DIV-1 (DIV >= 2), so the ticks stay low in reset.
  assign cpu_tick = (cpu_cnt == CPU_LAST);
  assign vdc_tick = (vdc_cnt == VDC_LAST);

  // Next-state logic: hold, then wait for a CPU tick, then run.
  always_comb begin
    state_d    = state;
    hold_cnt_d = '0;
    case (state)
      S_HOLD: begin
        if (ext_reset) begin
          hold_cnt_d = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_d = S_ALIGN;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt_d = hold_cnt + 1'b1;
        end else begin
          hold_cnt_d = hold_cnt;
        end
      end
      S_ALIGN: begin
        if (ext_reset) begin
          state_d = S_HOLD;
        end else if (cpu_tick) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (ext_reset) begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  // State register with registered sys_reset/running decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HOLD;
      hold_cnt  <= '0;
      sys_reset <= 1'b1;
      running   <= 1'b0;
    end else if (!rst_sync_n) begin
      state     <= S_HOLD;
      hold_cnt  <= '0;
      sys_reset <= 1'b1;
      running   <= 1'b0;
    end else begin
      state     <= state_d;
      hold_cnt  <= hold_cnt_d;
      sys_reset <= (state_d != S_RUN);
      running   <= (state_d == S_RUN);
    end
  end

`ifdef SYS_CE_PAUSE_EN
  logic pause_q;

  // Pause is captured only in S_RUN, so it masks ticks from the next cycle on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_q <= 1'b0;
    end else if (!rst_sync_n) begin
      pause_q <= 1'b0;
    end else begin
      pause_q <= pause && (state == S_RUN);
    end
  end

  // Masking drops whole pulses; the alignment tick itself is never gated.
  assign ce_cpu = cpu_tick && !(pause_q && (state == S_RUN));
`else
  assign ce_cpu = cpu_tick;
`endif

  assign ce_vdc = vdc_tick;

endmodule

// File: tb/tb_sys_clkrst_gen.sv
// Bench for sys_clkrst_gen with CPU_DIV=7, VDC_DIV=2, HOLD_CYCLES=16,
// SYNC_STAGES=2. Define SYS_CE_PAUSE_EN to also cover the pause input.
module tb_sys_clkrst_gen;

  localparam int CPU_DIV     = 7;
  localparam int VDC_DIV     = 2;
  localparam int HOLD_CYCLES = 16;
  localparam int SYNC_STAGES = 2;
  localparam int TL_LEN      = 1024;

  logic clk;
  logic rst_n;
  logic ext_reset;
  logic pause;
  logic sys_reset;
  logic running;
  logic ce_cpu;
  logic ce_vdc;

  sys_clkrst_gen #(
    .CPU_DIV    (CPU_DIV),
    .VDC_DIV    (VDC_DIV),
    .HOLD_CYCLES(HOLD_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ext_reset(ext_reset),
`ifdef SYS_CE_PAUSE_EN
    .pause    (pause),
`endif
    .sys_reset(sys_reset),
    .running  (running),
    .ce_cpu   (ce_cpu),
    .ce_vdc   (ce_vdc)
  );

  // Clock block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard state: expected {sys_reset, running, ce_cpu, ce_vdc}
  logic [3:0] exp_q[$];
  logic       sr_tl[TL_LEN];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = -100;
  int         ext_lo      = -100;
  int         ext_hi      = -100;
  int         p_lo        = -100;
  int         p_hi        = -100;
  logic [3:0] obs;
  logic [3:0] exp_v;

  // Expected sys_reset timeline: 1 up to rel_at-1, 0 from rel_at on.
  task automatic set_timeline(input int rel_at);
    for (int i = 0; i < TL_LEN; i++) sr_tl[i] = (i < rel_at);
  endtask

  task automatic set_sr(input int lo, input int hi, input logic v);
    for (int i = lo; i <= hi; i++) sr_tl[i] = v;
  endtask

  // Smallest cycle >= c in which the CPU divider fires.
  function automatic int next_tick(input int c);
    int t;
    t = c;
    while ((t % CPU_DIV) != CPU_DIV - 1) t++;
    return t;
  endfunction

  // Expected outputs for the current cycle from the timeline and divider phase.
  function automatic logic [3:0] model_vec();
    logic sr;
    logic cc;
    logic cv;
    if (cyc < 0) return 4'b1000;
    sr = sr_tl[cyc];
    cc = ((cyc % CPU_DIV) == CPU_DIV - 1);
    cv = ((cyc % VDC_DIV) == VDC_DIV - 1);
    if (!sr && (cyc >= p_lo + 1) && (cyc <= p_hi + 1)) cc = 1'b0;
    return {sr, !sr, cc, cv};
  endfunction

  // Driver: advance one cycle, drive that cycle's inputs, queue the expectation.
  task automatic drive_cycle();
    @(posedge clk);
    #1;
    cyc++;
    ext_reset = (cyc >= ext_lo) && (cyc <= ext_hi);
    pause     = (cyc >= p_lo) && (cyc <= p_hi);
    exp_q.push_back(model_vec());
  endtask

  // Hold rst_n low for a few cycles, then release it so cycle 0 follows two edges later.
  task automatic test_reset();
    rst_n     = 1'b0;
    ext_reset = 1'b0;
    pause     = 1'b0;
    ext_lo    = -100;
    ext_hi    = -100;
    p_lo      = -100;
    p_hi      = -100;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back(4'b1000);
      obs   = {sys_reset, running, ce_cpu, ce_vdc};
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL reset_hold i=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = -2;
  endtask

  // Power-up: release at 21, first running ce_cpu at 27.
  task automatic test_powerup(input int last);
    set_timeline(21);
    while (cyc < last) begin
      drive_cycle();
      obs   = {sys_reset, running, ce_cpu, ce_vdc};
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL powerup cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
    end
  endtask

  // One-cycle ext_reset at 100: reset from 101, align 117, tick 118, release 119.
  task automatic test_ext_pulse();
    ext_lo = 100;
    ext_hi = 100;
    set_sr(101, 118, 1'b1);
    while (cyc < 130) begin
      drive_cycle();
      obs   = {sys_reset, running, ce_cpu, ce_vdc};
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL ext_pulse cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
    end
  endtask

  // ext_reset held 140..189: hold restarts at 190, release after the next tick.
  task automatic test_ext_hold();
    int rel;
    ext_lo = 140;
    ext_hi = 189;
    rel = next_tick(190 + HOLD_CYCLES) + 1;
    set_sr(141, rel - 1, 1'b1);
    while (cyc < 230) begin
      drive_cycle();
      obs   = {sys_reset, running, ce_cpu, ce_vdc};
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL ext_hold cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
    end
  endtask

  // rst_n dropped between clock edges, in S_RUN and then mid-S_ALIGN.
  task automatic test_async_reset();
    drive_cycle();
    obs   = {sys_reset, running, ce_cpu, ce_vdc};
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL async_pre_run cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(4'b1000);
    obs   = {sys_reset, running, ce_cpu, ce_vdc};
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL async_in_run got=%b exp=%b", obs, exp_v);
    end
    test_reset();
    test_powerup(20);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(4'b1000);
    obs   = {sys_reset, running, ce_cpu, ce_vdc};
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL async_in_align got=%b exp=%b", obs, exp_v);
    end
    test_reset();
    test_powerup(40);
  endtask

  // ext_reset at 18 in S_ALIGN: hold 19..34, align 35, tick 41, release 42.
  task automatic test_ext_in_align();
    test_reset();
    ext_lo = 18;
    ext_hi = 18;
    set_timeline(42);
    while (cyc < 60) begin
      drive_cycle();
      obs   = {sys_reset, running, ce_cpu, ce_vdc};
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL ext_in_align cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
    end
  endtask

`ifdef SYS_CE_PAUSE_EN
  // pause 30..45 in S_RUN: ce_cpu at 34 and 41 dropped, resumes at 48.
  task automatic test_pause();
    test_reset();
    p_lo = 30;
    p_hi = 45;
    set_timeline(21);
    while (cyc < 60) begin
      drive_cycle();
      obs   = {sys_reset, running, ce_cpu, ce_vdc};
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL pause cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
    end
  endtask
`endif

  // Test sequence and final report
  initial begin
    rst_n     = 1'b0;
    ext_reset = 1'b0;
    pause     = 1'b0;
    test_reset();
    test_powerup(40);
    test_ext_pulse();
    test_ext_hold();
    test_async_reset();
    test_ext_in_align();
`ifdef SYS_CE_PAUSE_EN
    test_pause();
`endif
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
